// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: operator-stepped sequencer for a switch-driven ALU.
// Each press of the step button advances the sequence. The presses load
// operand A, then operand B, then the opcode. The block then waits for the
// ALU to settle, pulses the result load, and holds the result until the
// next press.
//
// state    | meaning
// ---------+-----------------------------------------------------
// WAIT_A   | idle, next press loads operand A
// WAIT_B   | next press loads operand B
// WAIT_OP  | next press latches opcode from sw[31:28]
// SETTLE   | ALU settling, down-counter running, presses ignored
// FIRE     | result/flag load pulse, presses ignored
// SHOW     | result valid (done=1), next press returns to WAIT_A
module alu_seq_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [31:0] sw,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_f,
  output logic [3:0]  op_q,
  output logic [2:0]  phase,
  output logic        done
);

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_FIRE    = 3'd4;
  localparam logic [2:0] ST_SHOW    = 3'd5;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  logic       step_s1;
  logic       step_s2;
  logic       step_d;
  logic       prime;
  logic       armed;
  logic       step_pulse;
  logic [2:0] state;
  logic [3:0] cnt;
  logic       unused_sw;

  // Only the opcode field of the switches is used here.
  assign unused_sw = ^sw[27:0];

  // Synchronize step and detect its rising edge. The first edge after reset
  // only primes the logic. Edge detection is armed only once a synchronized
  // low has actually been sampled. A button held through reset release
  // therefore cannot produce a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
      prime   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
      prime   <= 1'b1;
      if (prime && !step_s1) armed <= 1'b1;
    end
  end

  assign step_pulse = step_s2 & ~step_d & armed;

  // Sequencer: registered load strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_A;
      cnt   <= 4'd0;
      op_q  <= 4'd0;
      ld_a  <= 1'b0;
      ld_b  <= 1'b0;
      ld_f  <= 1'b0;
    end else begin
      ld_a <= 1'b0;
      ld_b <= 1'b0;
      ld_f <= 1'b0;
      case (state)
        ST_WAIT_A: begin
          if (step_pulse) begin
            ld_a  <= 1'b1;
            state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (step_pulse) begin
            ld_b  <= 1'b1;
            state <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          if (step_pulse) begin
            op_q  <= sw[31:28];
            cnt   <= CNT_INIT;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // ld_f is raised on the exit edge so it is high exactly while in FIRE.
          if (cnt == 4'd0) begin
            ld_f  <= 1'b1;
            state <= ST_FIRE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_FIRE: begin
          state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (step_pulse) state <= ST_WAIT_A;
        end
        default: begin
          state <= ST_WAIT_A;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign phase = state;
  assign done  = (state == ST_SHOW);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: one instance with SETTLE=2, one with SETTLE=8.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, step;
  logic [31:0] sw;
  logic        ld_a, ld_b, ld_f, done;
  logic [3:0]  op_q;
  logic [2:0]  phase;

  logic        rst8, step8;
  logic [31:0] sw8;
  logic        ld_a8, ld_b8, ld_f8, done8;
  logic [3:0]  op_q8;
  logic [2:0]  phase8;

  int checks = 0;
  int errors = 0;
  int k, n_a, n_b, n_f;

  alu_seq_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .step(step), .sw(sw),
    .ld_a(ld_a), .ld_b(ld_b), .ld_f(ld_f),
    .op_q(op_q), .phase(phase), .done(done)
  );

  alu_seq_ctrl #(.SETTLE(8)) dut8 (
    .clk(clk), .rst(rst8), .step(step8), .sw(sw8),
    .ld_a(ld_a8), .ld_b(ld_b8), .ld_f(ld_f8),
    .op_q(op_q8), .phase(phase8), .done(done8)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press();
    step = 1'b1;
    cyc(3);
    step = 1'b0;
    cyc(3);
  endtask

  task automatic press8();
    step8 = 1'b1;
    cyc(3);
    step8 = 1'b0;
    cyc(3);
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; sw = 32'h0;
    rst8 = 1'b1; step8 = 1'b0; sw8 = 32'h0;
    cyc(3);
    chk("rst_phase", phase, 0);
    chk("rst_ld_a", ld_a, 0);
    chk("rst_ld_b", ld_b, 0);
    chk("rst_ld_f", ld_f, 0);
    chk("rst_op_q", op_q, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; rst8 = 1'b0;
    cyc(3);

    // operand A press, held 100 cycles
    step = 1'b1;
    cyc(2);
    chk("lat_a_early", ld_a, 0);
    cyc(1);
    chk("lat_a", ld_a, 1);
    chk("phase_b", phase, 1);
    n_a = 0; n_b = 0;
    repeat (100) begin
      cyc(1);
      n_a += int'(ld_a);
      n_b += int'(ld_b);
    end
    chk("hold_extra_a", n_a, 0);
    chk("hold_b", n_b, 0);
    chk("hold_phase", phase, 1);
    step = 1'b0;
    cyc(3);

    // operand B press
    step = 1'b1;
    cyc(3);
    chk("ld_b_pulse", ld_b, 1);
    chk("ld_b_excl_a", ld_a, 0);
    chk("phase_op", phase, 2);
    step = 1'b0;
    cyc(1);
    chk("ld_b_single", ld_b, 0);
    cyc(2);

    // opcode press, SETTLE=2: ld_f three cycles after the pulse cycle
    sw = 32'h3ABC_DEF1;
    step = 1'b1;
    cyc(2);
    step = 1'b0;
    k = 0;
    while (ld_f !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    chk("lat_f_s2", k, 3);
    chk("op_q_latch", op_q, 4'h3);
    chk("phase_fire", phase, 4);
    cyc(1);
    chk("ld_f_single", ld_f, 0);
    chk("done_show", done, 1);
    chk("phase_show", phase, 5);
    sw = 32'hF000_0000;
    cyc(3);
    chk("op_q_hold_show", op_q, 4'h3);
    chk("done_hold", done, 1);
    step = 1'b1;
    cyc(3);
    chk("show_to_a_phase", phase, 0);
    chk("show_to_a_done", done, 0);
    chk("show_to_a_op_q", op_q, 4'h3);
    step = 1'b0;
    cyc(3);

    // reset while in SETTLE with counter=1
    press();
    press();
    sw = 32'h5000_0000;
    step = 1'b1;
    cyc(3);
    chk("settle_entry", phase, 3);
    rst = 1'b1;
    cyc(1);
    chk("abort_phase", phase, 0);
    chk("abort_op_q", op_q, 0);
    chk("abort_ld_f", ld_f, 0);
    rst = 1'b0;
    step = 1'b0;
    n_f = 0;
    repeat (20) begin
      cyc(1);
      n_f += int'(ld_f);
    end
    chk("abort_no_ld_f", n_f, 0);
    chk("abort_idle", phase, 0);

    // step held across reset release must not count as a press
    rst = 1'b1;
    step = 1'b1;
    cyc(3);
    rst = 1'b0;
    n_a = 0;
    repeat (10) begin
      cyc(1);
      n_a += int'(ld_a);
    end
    chk("held_rel_no_a", n_a, 0);
    chk("held_rel_phase", phase, 0);
    step = 1'b0;
    cyc(3);
    step = 1'b1;
    cyc(3);
    chk("new_edge_a", ld_a, 1);
    step = 1'b0;
    cyc(3);

    // illegal state code 6 recovers to WAIT_A
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    force dut.state = 3'd6;
    @(posedge clk);
    #1;
    release dut.state;
    chk("illegal_loads", {ld_a, ld_b, ld_f}, 0);
    cyc(1);
    chk("illegal_phase", phase, 0);
    chk("illegal_done", done, 0);
    chk("illegal_loads2", {ld_a, ld_b, ld_f}, 0);

    // SETTLE=8: presses during SETTLE/FIRE dropped, sw toggles ignored
    press8();
    press8();
    chk("s8_phase_op", phase8, 2);
    sw8 = 32'h6000_0000;
    step8 = 1'b1;
    cyc(2);
    step8 = 1'b0;
    k = 0; n_a = 0; n_b = 0;
    while (ld_f8 !== 1'b1 && k < 30) begin
      cyc(1);
      k++;
      n_a += int'(ld_a8);
      n_b += int'(ld_b8);
      if (k == 2) begin
        sw8 = 32'hF000_0000;
        step8 = 1'b1;
      end
      if (k == 4) step8 = 1'b0;
      if (k == 6) step8 = 1'b1;
      if (k == 7) step8 = 1'b0;
    end
    chk("lat_f_s8", k, 9);
    chk("s8_phase_fire", phase8, 4);
    chk("s8_no_loads", n_a + n_b, 0);
    cyc(1);
    chk("s8_phase_show", phase8, 5);
    chk("s8_done", done8, 1);
    chk("s8_op_q", op_q8, 4'h6);
    cyc(4);
    chk("s8_stay_show", phase8, 5);
    chk("s8_op_q_hold", op_q8, 4'h6);
    sw8 = 32'h0;
    step8 = 1'b1;
    cyc(3);
    chk("s8_back_a", phase8, 0);
    chk("s8_done_drop", done8, 0);
    chk("s8_op_q_keep", op_q8, 4'h6);
    step8 = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
